// File: rtl/wb_decoder_n_if.sv
// Wishbone classic bus bundle between one CPU master and the decoder's slave fan-out.
// The decoder connects through the 'slave' modport (it is the slave of the CPU master
// and drives the per-port slave signals); the environment uses the 'master' modport.
interface wb_decoder_n_if #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NPORTS = 16
);
    // master side
    logic                   m_cyc_i;
    logic                   m_stb_i;
    logic                   m_we_i;
    logic [DW/8-1:0]        m_sel_i;
    logic [AW-1:0]          m_adr_i;
    logic [DW-1:0]          m_dat_i;
    logic [DW-1:0]          m_dat_o;
    logic                   m_ack_o;
    logic                   m_err_o;
    // slave side
    logic [NPORTS-1:0]      s_cyc_o;
    logic [NPORTS-1:0]      s_stb_o;
    logic                   s_we_o;
    logic [DW/8-1:0]        s_sel_o;
    logic [AW-1:0]          s_adr_o;
    logic [DW-1:0]          s_dat_o;
    logic [NPORTS*DW-1:0]   s_dat_i;
    logic [NPORTS-1:0]      s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_decoder_n.sv
// Parametrised Wishbone classic address decoder, one master to NPORTS slave ports.
// The port is chosen from m_adr_i[BASE +: log2(NPORTS)] and held for the whole cycle.
// Unpopulated ports terminate with m_err_o; the last error cause/address are latched.
// Optional watchdog: define WB_DECODE_TIMEOUT_EN to terminate stalled cycles after
// TIMEOUT cycles without ack (err_code_o = 10). Without it BUSY waits indefinitely.
module wb_decoder_n #(
    parameter int                AW        = 32,
    parameter int                DW        = 32,
    parameter int                NPORTS    = 16,
    parameter int                BASE      = 28,
    parameter logic [NPORTS-1:0] PORT_MASK = {NPORTS{1'b1}},
    parameter int                TIMEOUT   = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_decoder_n_if.slave   bus,
    output logic            err_irq_o,
    output logic [1:0]      err_code_o,
    output logic [AW-1:0]   err_adr_o
);
    localparam int PW = $clog2(NPORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [PW-1:0]      sel_reg;
    logic [PW-1:0]      decode;
    logic               req;
    logic               busy;
    logic               ack;
    logic               timeout_hit;
    logic               err_irq_reg;
    logic [1:0]         err_code_reg;
    logic [AW-1:0]      err_adr_reg;
    logic [DW-1:0]      port_dat [NPORTS];
    logic [NPORTS-1:0]  s_cyc_vec;
    logic [NPORTS-1:0]  s_stb_vec;

    assign decode = bus.m_adr_i[BASE +: PW];
    assign req    = bus.m_cyc_i & bus.m_stb_i;
    assign busy   = (state_reg == ST_BUSY);
    // only the selected port's ack can terminate; all others are ignored
    assign ack    = busy & bus.s_ack_i[sel_reg] & bus.m_stb_i;

    // unpack the flat slave read-data bus and build per-port cycle/strobe
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign port_dat[gi]  = bus.s_dat_i[gi*DW +: DW];
            assign s_cyc_vec[gi] = busy & (sel_reg == PW'(gi)) & bus.m_cyc_i;
            assign s_stb_vec[gi] = busy & (sel_reg == PW'(gi)) & bus.m_stb_i;
        end
    endgenerate

`ifdef WB_DECODE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_reg;

    // ack has priority: a timeout only fires in a cycle with no ack
    assign timeout_hit = busy & bus.m_cyc_i & ~ack & (cnt_reg == CW'(TIMEOUT));

    // watchdog: cleared on entry to BUSY, counts unacked BUSY cycles, saturates
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_IDLE && req) begin
            cnt_reg <= '0;
        end else if (busy && !ack && cnt_reg != CW'(TIMEOUT)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = PORT_MASK[decode] ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                if (ack || !bus.m_cyc_i || timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // master-side outputs decoded from state and the held selection
    always_comb begin
        bus.m_ack_o = ack;
        bus.m_err_o = (state_reg == ST_ERR) | timeout_hit;
        bus.m_dat_o = busy ? port_dat[sel_reg] : '0;
    end

    assign bus.s_cyc_o = s_cyc_vec;
    assign bus.s_stb_o = s_stb_vec;

    // shared slave copies follow the master, forced low while reset is held
    assign bus.s_we_o  = rst_i & bus.m_we_i;
    assign bus.s_sel_o = rst_i ? bus.m_sel_i : '0;
    assign bus.s_adr_o = rst_i ? bus.m_adr_i : '0;
    assign bus.s_dat_o = rst_i ? bus.m_dat_i : '0;

    // port selection is captured only when a request leaves IDLE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel_reg <= '0;
        end else if (state_reg == ST_IDLE && req) begin
            sel_reg <= decode;
        end
    end

    // error cause/address latch, held until the next error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_code_reg <= 2'b00;
            err_adr_reg  <= '0;
        end else if (state_reg == ST_IDLE && req && !PORT_MASK[decode]) begin
            err_code_reg <= 2'b01;
            err_adr_reg  <= bus.m_adr_i;
        end else if (timeout_hit) begin
            err_code_reg <= 2'b10;
            err_adr_reg  <= bus.m_adr_i;
        end
    end

    // interrupt pulse one cycle after any bus error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_irq_reg <= 1'b0;
        end else begin
            err_irq_reg <= bus.m_err_o;
        end
    end

    assign err_irq_o  = err_irq_reg;
    assign err_code_o = err_code_reg;
    assign err_adr_o  = err_adr_reg;
endmodule

// File: tb/tb_wb_decoder_n.sv
// Scoreboard bench for wb_decoder_n: the driver pushes expected terminations,
// a negedge monitor pops and compares whenever m_ack_o or m_err_o appears.
// Watchdog tests depend on WB_DECODE_TIMEOUT_EN.
module tb_wb_decoder_n;
    logic        clk;
    logic        rst_i;
    logic        err_irq_o;
    logic [1:0]  err_code_o;
    logic [31:0] err_adr_o;
    logic [15:0] ack_en;
    logic [15:0] rogue_ack;
    int          cycle_cnt;
    int          checks;
    int          failures;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        logic [1:0]  code;
        logic [31:0] adr;
        int          issue;
        int          lat;
    } exp_t;

    exp_t q[$];

    wb_decoder_n_if #(.AW(32), .DW(32), .NPORTS(16)) bus ();

    wb_decoder_n #(
        .AW(32), .DW(32), .NPORTS(16), .BASE(28),
        .PORT_MASK(16'h00FF), .TIMEOUT(8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus),
        .err_irq_o (err_irq_o),
        .err_code_o(err_code_o),
        .err_adr_o (err_adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // slave model: enabled ports ack combinationally while strobed; rogue acks are raw
    assign bus.s_ack_i = (ack_en & bus.s_stb_o) | rogue_ack;

    function automatic logic [31:0] port_word(input int p);
        return (p == 3) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(p * 17));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // monitor: every termination must match the head of the scoreboard
    bit          err_follow;
    logic [1:0]  fol_code;
    logic [31:0] fol_adr;
    initial begin
        exp_t e;
        err_follow = 0;
        forever begin
            @(negedge clk);
            if (err_follow) begin
                err_follow = 0;
                chk("err_irq_pulse", err_irq_o, 1'b1);
                chk("err_code", err_code_o, fol_code);
                chk("err_adr", err_adr_o, fol_adr);
            end else if (rst_i && err_irq_o) begin
                chk("unexpected_irq", err_irq_o, 1'b0);
            end
            if (rst_i && (bus.m_ack_o || bus.m_err_o)) begin
                if (q.size() == 0) begin
                    chk("unexpected_term", {bus.m_ack_o, bus.m_err_o}, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("term_latency", 64'(cycle_cnt - e.issue), 64'(e.lat));
                    chk("term_err", bus.m_err_o, e.is_err);
                    chk("term_ack", bus.m_ack_o, !e.is_err);
                    if (!e.is_err) begin
                        chk("read_data", bus.m_dat_o, e.dat);
                    end else begin
                        err_follow = 1;
                        fol_code   = e.code;
                        fol_adr    = e.adr;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] wdat);
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.m_we_i  = we;
        bus.m_sel_i = 4'hF;
        bus.m_adr_i = adr;
        bus.m_dat_i = wdat;
    endtask

    task automatic idle();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // drive one access, push its expectation, wait (bounded) for termination
    task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [15:0] exp_stb, input bit e_err, input logic [31:0] e_dat,
                          input logic [1:0] e_code, input int e_lat, input int budget);
        exp_t e;
        bit   done;
        e.is_err = e_err;
        e.dat    = e_dat;
        e.code   = e_code;
        e.adr    = adr;
        e.issue  = cycle_cnt;
        e.lat    = e_lat;
        q.push_back(e);
        issue(adr, we, wdat);
        done = 0;
        for (int n = 0; n <= budget && !done; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk("stb_cycle0", bus.s_stb_o, 16'h0000);
                chk("pass_adr", bus.s_adr_o, adr);
                chk("pass_we", bus.s_we_o, we);
                chk("pass_dat", bus.s_dat_o, wdat);
            end
            if (n == 1) chk("stb_cycle1", bus.s_stb_o, exp_stb);
            if (bus.m_ack_o || bus.m_err_o) done = 1;
        end
        if (!done) chk("term_wait_expired", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired expected=done");
        $fatal(1, "time limit");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cycle_cnt = 0;
        ack_en    = 16'h0000;
        rogue_ack = 16'h0000;
        rst_i     = 1'b0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_we_i  = 1'b0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        for (int p = 0; p < 16; p++) bus.s_dat_i[p*32 +: 32] = port_word(p);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_cyc", bus.s_cyc_o, 16'h0000);
        chk("rst_ack_err", {bus.m_ack_o, bus.m_err_o}, 2'b00);
        chk("rst_err_regs", {err_irq_o, err_code_o, err_adr_o}, 35'h0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // read port 3, then back-to-back read port 1
        ack_en = 16'h000B;
        access(32'h3000_0010, 1'b0, 32'h0, 16'h0008, 0, 32'hDEADBEEF, 2'b00, 1, 10);
        access(32'h1000_0004, 1'b0, 32'h0, 16'h0002, 0, port_word(1), 2'b00, 1, 10);
        idle();
        chk("idle_after_read", bus.s_stb_o, 16'h0000);

        // unmapped write
        access(32'h9000_0000, 1'b1, 32'h1234_5678, 16'h0000, 1, 32'h0, 2'b01, 1, 10);
        idle();
        idle();

`ifdef WB_DECODE_TIMEOUT_EN
        // port 5 never acks -> timeout error at cycle 9
        ack_en = 16'h0001;
        access(32'h5000_0040, 1'b0, 32'h0, 16'h0020, 1, 32'h0, 2'b10, 9, 20);
        access(32'h0000_0100, 1'b0, 32'h0, 16'h0001, 0, port_word(0), 2'b00, 1, 10);
        idle();
        idle();
        // port 5 acks exactly when the counter reaches TIMEOUT -> ack wins
        ack_en = 16'h0000;
        fork
            begin
                repeat (9) @(posedge clk);
                #1;
                ack_en[5] = 1'b1;
            end
        join_none
        access(32'h5000_0080, 1'b0, 32'h0, 16'h0020, 0, port_word(5), 2'b00, 9, 20);
        idle();
        ack_en = 16'h0000;
        chk("code_after_late_ack", {err_irq_o, err_code_o}, 3'b010);
`else
        // without the watchdog a stalled port keeps BUSY and never errors
        ack_en = 16'h0000;
        issue(32'h5000_0040, 1'b0, 32'h0);
        repeat (20) @(negedge clk);
        chk("stall_still_busy", bus.s_stb_o, 16'h0020);
        @(posedge clk);
        #1;
        idle();
        chk("stall_no_timeout_code", {err_irq_o, err_code_o}, 3'b001);
`endif

        // master abandons a port-2 cycle at cycle 3; port 7 acks out of turn
        ack_en    = 16'h0000;
        rogue_ack = 16'h0080;
        issue(32'h2000_0000, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus.m_cyc_i = 1'b0;
        #1;
        chk("drop_s_cyc", bus.s_cyc_o, 16'h0000);
        chk("drop_s_stb_still", bus.s_stb_o, 16'h0004);
        @(posedge clk);
        #1;
        chk("drop_idle_next", bus.s_stb_o, 16'h0000);
        bus.m_stb_i = 1'b0;
        rogue_ack   = 16'h0000;
        idle();
        chk("drop_no_irq", err_irq_o, 1'b0);

        // asynchronous reset in the middle of a BUSY cycle to port 4
        issue(32'h4000_0000, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_s_cyc_stb", {bus.s_cyc_o, bus.s_stb_o}, 32'h0);
        chk("arst_master_out", {bus.m_ack_o, bus.m_err_o, bus.m_dat_o}, 34'h0);
        chk("arst_err_regs", {err_irq_o, err_code_o, err_adr_o}, 35'h0);
        chk("arst_pass_adr", bus.s_adr_o, 32'h0);
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        ack_en = 16'h0002;
        access(32'h1000_0000, 1'b0, 32'h0, 16'h0002, 0, port_word(1), 2'b00, 1, 10);
        idle();
        idle();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
